// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-style RAM controller.
//   - Command opcodes carried in din[DATA_WIDTH+1:DATA_WIDTH]
//   - Controller FSM state encoding
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StTxWait = 1'b1
  } state_e;

endpackage

// File: rtl/ram_sp_array.sv
// Single-port word array: one write or one read per cycle.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   addr  - shared read/write address
//   wdata - write data
//   rdata - combinational read data; all-zero for addresses >= MEM_DEPTH
// Contents are never reset. Out-of-range writes are dropped.
module ram_sp_array #(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 2 ** ADDR_SIZE
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DepthW = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  in_range;

  assign in_range = {1'b0, addr} < DepthW;

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr[IdxW-1:0]] <= wdata;
    end
  end

  assign rdata = in_range ? mem[addr[IdxW-1:0]] : '0;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-driven RAM controller with separate write and read address pointers.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   din      - {opcode[1:0], payload[DATA_WIDTH-1:0]}
//   rx_valid - din carries a command
//   rx_ready - command accepted when high together with rx_valid
//   dout     - read data, held stable while tx_valid is high
//   tx_valid - dout valid
//   tx_ready - consumer takes dout
//   err      - sticky: dropped command or out-of-range access; cleared by rst only
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 2 ** ADDR_SIZE,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  err
);

  localparam logic [ADDR_SIZE:0] DepthW = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] LastW  = DepthW - 1'b1;

  state_e state_q, state_d;

  logic [ADDR_SIZE-1:0]  addr_wr_q, addr_rd_q;
  logic [ADDR_SIZE-1:0]  addr_wr_inc, addr_rd_inc;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  err_q;

  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] payload;
  logic                  accept;
  logic                  wr_addr_acc, wr_data_acc, rd_addr_acc, rd_data_acc;
  logic                  dropped;
  logic [ADDR_SIZE-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_addr_ok;

  assign op      = din[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = din[DATA_WIDTH-1:0];

  assign accept      = rx_valid && rx_ready;
  assign wr_addr_acc = accept && (op == OP_WR_ADDR);
  assign wr_data_acc = accept && (op == OP_WR_DATA);
  assign rd_addr_acc = accept && (op == OP_RD_ADDR);
  assign rd_data_acc = accept && (op == OP_RD_DATA);
  assign dropped     = rx_valid && !rx_ready;

  // Single port: the write pointer owns the port only on an accepted write.
  assign ram_addr    = wr_data_acc ? addr_wr_q : addr_rd_q;
  assign ram_addr_ok = {1'b0, ram_addr} < DepthW;

  // Wrap to zero after the last implemented word; out-of-range pointers just count on.
  always_comb begin
    addr_wr_inc = addr_wr_q + 1'b1;
    addr_rd_inc = addr_rd_q + 1'b1;
    if ({1'b0, addr_wr_q} == LastW) addr_wr_inc = '0;
    if ({1'b0, addr_rd_q} == LastW) addr_rd_inc = '0;
  end

  ram_sp_array #(
    .ADDR_SIZE  (ADDR_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_data_acc),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (ram_rdata)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rd_data_acc) state_d = StTxWait;
      StTxWait: if (tx_ready)    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: decoded from the state register only
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    unique case (state_q)
      StIdle:   rx_ready = 1'b1;
      StTxWait: tx_valid = 1'b1;
      default:  rx_ready = 1'b0;
    endcase
  end

  // Address pointers, read data and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_wr_q <= '0;
      addr_rd_q <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (wr_addr_acc) addr_wr_q <= payload[ADDR_SIZE-1:0];
      else if (wr_data_acc && AUTO_INC) addr_wr_q <= addr_wr_inc;

      if (rd_addr_acc) addr_rd_q <= payload[ADDR_SIZE-1:0];
      else if (rd_data_acc && AUTO_INC) addr_rd_q <= addr_rd_inc;

      // Only loaded on accept, so dout holds through TX_WAIT.
      if (rd_data_acc) dout_q <= ram_rdata;

      if (dropped || ((wr_data_acc || rd_data_acc) && !ram_addr_ok)) err_q <= 1'b1;
    end
  end

  assign dout = dout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench: vector table for the default-parameter controller, then
// hand sequences on a non-incrementing, 64-word instance.
module tb_spi_ram_ctrl;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] WD = 2'b01;
  localparam logic [1:0] RA = 2'b10;
  localparam logic [1:0] RD = 2'b11;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] op;
    logic [7:0] data;
    logic       txr;
    logic       e_rdy;
    logic       e_tv;
    logic [7:0] e_dout;
    logic       e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, rx_valid, tx_ready;
  logic [9:0] din;
  logic       rx_ready, tx_valid, err;
  logic [7:0] dout;

  logic       rst2, rx_valid2, tx_ready2;
  logic [9:0] din2;
  logic       rx_ready2, tx_valid2, err2;
  logic [7:0] dout2;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  spi_ram_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .dout     (dout),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err      (err)
  );

  spi_ram_ctrl #(
    .ADDR_SIZE  (8),
    .DATA_WIDTH (8),
    .MEM_DEPTH  (64),
    .AUTO_INC   (1'b0)
  ) dut2 (
    .clk      (clk),
    .rst      (rst2),
    .din      (din2),
    .rx_valid (rx_valid2),
    .rx_ready (rx_ready2),
    .dout     (dout2),
    .tx_valid (tx_valid2),
    .tx_ready (tx_ready2),
    .err      (err2)
  );

  function automatic vec_t v(logic r, logic vl, logic [1:0] o, logic [7:0] d, logic t,
                             logic erdy, logic etv, logic [7:0] edo, logic ee);
    vec_t x;
    x.rst = r; x.vld = vl; x.op = o; x.data = d; x.txr = t;
    x.e_rdy = erdy; x.e_tv = etv; x.e_dout = edo; x.e_err = ee;
    return x;
  endfunction

  task automatic check(string name, logic rdy, logic tv, logic [7:0] d, logic e,
                       logic erdy, logic etv, logic [7:0] edo, logic ee);
    n_vec++;
    if (rdy !== erdy || tv !== etv || d !== edo || e !== ee) begin
      n_bad++;
      $display("FAIL %s: got rx_ready=%0b tx_valid=%0b dout=%02h err=%0b, want %0b %0b %02h %0b",
               name, rdy, tv, d, e, erdy, etv, edo, ee);
    end
  endtask

  // Drive dut2 for one cycle, then check just after the edge.
  task automatic step2(string name, logic r, logic vl, logic [1:0] o, logic [7:0] d, logic t,
                       logic erdy, logic etv, logic [7:0] edo, logic ee);
    rst2 = r; rx_valid2 = vl; din2 = {o, d}; tx_ready2 = t;
    @(posedge clk); #1;
    check(name, rx_ready2, tx_valid2, dout2, err2, erdy, etv, edo, ee);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; din = '0; tx_ready = 1'b0;
    rst2 = 1'b1; rx_valid2 = 1'b0; din2 = '0; tx_ready2 = 1'b0;

    //              rst vld op  data   txr  rdy tv dout   err
    // reset, including reset beating a command
    tbl.push_back(v(1, 0, WA, 8'h00, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(1, 1, RD, 8'h00, 1,  1, 0, 8'h00, 0));
    // burst write at 0x10, burst read back
    tbl.push_back(v(0, 1, WA, 8'h10, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, WD, 8'hA1, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, WD, 8'hA2, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, WD, 8'hA3, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, RA, 8'h10, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, RD, 8'h5A, 1,  0, 1, 8'hA1, 0));
    tbl.push_back(v(0, 0, WA, 8'h00, 1,  1, 0, 8'hA1, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'hA2, 0));
    tbl.push_back(v(0, 0, WA, 8'h00, 1,  1, 0, 8'hA2, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'hA3, 0));
    tbl.push_back(v(0, 0, WA, 8'h00, 1,  1, 0, 8'hA3, 0));
    // backpressure: rx_valid held high during TX_WAIT
    tbl.push_back(v(0, 1, RA, 8'h10, 0,  1, 0, 8'hA3, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 0,  0, 1, 8'hA1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, 1, RD, 8'h00, 0,  0, 1, 8'hA1, 1));
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'hA1, 1));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'hA2, 1)); // addr_rd advanced once only
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'hA2, 1));
    // wrap at the top of memory
    tbl.push_back(v(1, 0, WA, 8'h00, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, WA, 8'hFF, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, WD, 8'h11, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, WD, 8'h22, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, RA, 8'hFF, 0,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'h11, 0));
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'h11, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'h22, 0));
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'h22, 0));
    // read one cycle after a write to the same address
    tbl.push_back(v(0, 1, RA, 8'h40, 0,  1, 0, 8'h22, 0));
    tbl.push_back(v(0, 1, WA, 8'h40, 0,  1, 0, 8'h22, 0));
    tbl.push_back(v(0, 1, WD, 8'h7E, 0,  1, 0, 8'h22, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'h7E, 0));
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'h7E, 0));
    // din ignored while rx_valid is low
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'h7E, 0));
    tbl.push_back(v(0, 0, RA, 8'h10, 1,  1, 0, 8'h7E, 0));
    // reset while in TX_WAIT; memory survives, pointers return to 0
    tbl.push_back(v(0, 1, RA, 8'h10, 0,  1, 0, 8'h7E, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 0,  0, 1, 8'hA1, 0));
    tbl.push_back(v(1, 1, RD, 8'h00, 1,  1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'h22, 0)); // mem[0x00]
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'h22, 0));
    tbl.push_back(v(0, 1, RA, 8'h10, 0,  1, 0, 8'h22, 0));
    tbl.push_back(v(0, 1, RD, 8'h00, 1,  0, 1, 8'hA1, 0));
    tbl.push_back(v(0, 0, RD, 8'h00, 1,  1, 0, 8'hA1, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; rx_valid = tbl[i].vld; din = {tbl[i].op, tbl[i].data};
      tx_ready = tbl[i].txr;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), rx_ready, tx_valid, dout, err,
            tbl[i].e_rdy, tbl[i].e_tv, tbl[i].e_dout, tbl[i].e_err);
    end

    // AUTO_INC=0, MEM_DEPTH=64
    step2("d2_reset",   1, 0, WA, 8'h00, 0,  1, 0, 8'h00, 0);
    step2("d2_wa",      0, 1, WA, 8'h20, 0,  1, 0, 8'h00, 0);
    step2("d2_wd55",    0, 1, WD, 8'h55, 0,  1, 0, 8'h00, 0);
    step2("d2_wd66",    0, 1, WD, 8'h66, 0,  1, 0, 8'h00, 0);
    step2("d2_ra",      0, 1, RA, 8'h20, 0,  1, 0, 8'h00, 0);
    step2("d2_rd1",     0, 1, RD, 8'h00, 1,  0, 1, 8'h66, 0);
    step2("d2_idle1",   0, 0, RD, 8'h00, 1,  1, 0, 8'h66, 0);
    step2("d2_rd2",     0, 1, RD, 8'h00, 1,  0, 1, 8'h66, 0);
    step2("d2_idle2",   0, 0, RD, 8'h00, 1,  1, 0, 8'h66, 0);
    // out-of-range write then read: dropped write, zero data, err set
    step2("d2_wa_oor",  0, 1, WA, 8'h50, 0,  1, 0, 8'h66, 0);
    step2("d2_wd_oor",  0, 1, WD, 8'h99, 0,  1, 0, 8'h66, 1);
    step2("d2_ra_oor",  0, 1, RA, 8'h50, 0,  1, 0, 8'h66, 1);
    step2("d2_rd_oor",  0, 1, RD, 8'h00, 1,  0, 1, 8'h00, 1);
    step2("d2_idle3",   0, 0, RD, 8'h00, 1,  1, 0, 8'h00, 1);
    // in-range data must be untouched by the dropped write
    step2("d2_ra_back", 0, 1, RA, 8'h20, 0,  1, 0, 8'h00, 1);
    step2("d2_rd_back", 0, 1, RD, 8'h00, 1,  0, 1, 8'h66, 1);
    step2("d2_rst_err", 1, 0, RD, 8'h00, 1,  1, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
